i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// I2S (Philips format) transmitter: a 32-bit frame FIFO feeds a serializer whose bit
// clock is divided down from WB_CLK. Left word in [31:16], right in [15:0], MSB first.
module i2s_tx #(
   parameter int unsigned CLK_DIV_HALF = 4,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        WB_CLK,
   input  logic        WB_RST_n,
   input  logic        Enable_i,
   input  logic [31:0] Smp_Data_i,
   input  logic        Smp_Valid_i,
   output logic        Smp_Ready_o,
   output logic [4:0]  FIFO_Level_o,
   input  logic        Underrun_Clr_i,
   output logic        Underrun_o,
   output logic        Frame_Done_o,
   output logic        I2S_CLK_o,
   output logic        I2S_WS_CLK_o,
   output logic        I2S_DOUT_o,
   output logic        Dbg_State_o
);

   localparam int          PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV_HALF - 1);
   localparam logic [4:0]  DEPTH5   = 5'(FIFO_DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    level;
   logic [7:0]    div_cnt;
   logic [4:0]    slot;
   logic [31:0]   shifter;

   logic          push, pop, running, div_wrap, fall_tick, load;
   logic [4:0]    slot_nxt;
   logic [31:0]   shift_nxt;

   // Sample handshake: a frame is taken on every WB_CLK edge where Smp_Valid_i and
   // Smp_Ready_o are both high; Smp_Ready_o depends only on the FIFO level.
   assign Smp_Ready_o  = (level < DEPTH5);
   assign FIFO_Level_o = level;
   assign Dbg_State_o  = (state_q == RUN);

   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      running   = 1'b0;
      div_wrap  = 1'b0;
      fall_tick = 1'b0;
      load      = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;
      slot_nxt  = slot + 5'd1;
      shift_nxt = shifter;

      case (state_q)
         IDLE:    if (Enable_i)  state_d = RUN;
         RUN:     if (!Enable_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Dropping Enable_i in RUN stops the serializer at this edge, so no tick fires.
      running   = (state_q == RUN) && Enable_i;
      div_wrap  = running && (div_cnt == DIV_LAST);
      fall_tick = div_wrap && I2S_CLK_o;
      load      = fall_tick && (slot == 5'd31);
      // Occupancy before this edge decides the load, so a same-cycle push cannot feed it.
      pop       = load && (level != 5'd0);
      push      = Smp_Valid_i && Smp_Ready_o;

      if (load) begin
         shift_nxt = pop ? mem[rd_ptr] : 32'h0;
      end
   end

   always_ff @(posedge WB_CLK) begin
      if (push) begin
         mem[wr_ptr] <= Smp_Data_i;
      end
   end

   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level <= level + 5'd1;
            2'b01:   level <= level - 5'd1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
      if (!WB_RST_n) begin
         div_cnt      <= 8'd0;
         slot         <= 5'd31;
         shifter      <= 32'h0;
         I2S_CLK_o    <= 1'b0;
         I2S_WS_CLK_o <= 1'b0;
         I2S_DOUT_o   <= 1'b0;
         Frame_Done_o <= 1'b0;
         Underrun_o   <= 1'b0;
      end else begin
         Frame_Done_o <= load;

         if (!running) begin
            div_cnt      <= 8'd0;
            slot         <= 5'd31;
            I2S_CLK_o    <= 1'b0;
            I2S_WS_CLK_o <= 1'b0;
            I2S_DOUT_o   <= 1'b0;
         end else begin
            if (div_wrap) begin
               div_cnt   <= 8'd0;
               I2S_CLK_o <= ~I2S_CLK_o;
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
            // WS leads data by one bit: it flips on slot 15/31, data word changes on 16/0.
            if (fall_tick) begin
               slot         <= slot_nxt;
               shifter      <= shift_nxt;
               I2S_WS_CLK_o <= (slot_nxt >= 5'd15) && (slot_nxt <= 5'd30);
               I2S_DOUT_o   <= shift_nxt[5'd31 - slot_nxt];
            end
         end

         if (load && !pop) begin
            Underrun_o <= 1'b1;
         end else if (Underrun_Clr_i) begin
            Underrun_o <= 1'b0;
         end
      end
   end

endmodule
